// File: rtl/pipe_alu_if.sv
// pipe_alu_if -- request/response bundle between a requester and pipe_alu.
//   Request side : in_valid, in_ready, op[3:0], a[WIDTH-1:0], b[WIDTH-1:0]
//   Response side: out_valid, out_ready, result[WIDTH-1:0], zero, carry, overflow
//   master modport: the requester/consumer driving operands and taking results.
//   slave modport : the ALU itself.
interface pipe_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, overflow
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, overflow
  );
endinterface

// File: rtl/pipe_alu.sv
// pipe_alu -- single-request ALU with an iterative one-bit-per-cycle shifter.
//   clk : sole clock, rising edge
//   rst : asynchronous active-high reset
//   bus : pipe_alu_if slave modport
//         op 0 ADD, 1 SUB, 2 NOT, 3 AND, 4 OR, 5 XOR, 6 SLT, 7 EQ, 8 SLTU,
//         9 SLL, 10 SRL, 11 SRA (amount b[SHW-1:0]); 12-15 give 0 with flags 0.
//   Non-shift ops answer one cycle after accept; shifts take 1+k cycles.
//   Results hold in DONE until out_ready.
module pipe_alu #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  pipe_alu_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] shifted;

  // One shared adder: SUB is a + ~b + 1, so bit WIDTH is "no borrow".
  always_comb begin
    is_sub = (bus.op == OP_SUB);
    b_eff  = is_sub ? ~bus.b : bus.b;
    sum    = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
  end

  // The result register doubles as the shift register while in SHIFT.
  always_comb begin
    case (op_q)
      OP_SLL:  shifted = {result_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, result_q[WIDTH-1:1]};
      OP_SRA:  shifted = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: shifted = result_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_d     = zero_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d       = bus.op;
          cnt_d      = '0;
          carry_d    = 1'b0;
          overflow_d = 1'b0;
          state_d    = DONE;
          case (bus.op)
            OP_ADD, OP_SUB: begin
              result_d   = sum[WIDTH-1:0];
              carry_d    = sum[WIDTH];
              overflow_d = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_NOT:  result_d = ~bus.a;
            OP_AND:  result_d = bus.a & bus.b;
            OP_OR:   result_d = bus.a | bus.b;
            OP_XOR:  result_d = bus.a ^ bus.b;
            OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_EQ:   result_d = {{(WIDTH-1){1'b0}}, (bus.a == bus.b)};
            OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL, OP_SRL, OP_SRA: begin
              result_d = bus.a;
              cnt_d    = bus.b[SHW-1:0];
              if (bus.b[SHW-1:0] != '0) state_d = SHIFT;
            end
            default: result_d = '0;
          endcase
          // Reserved codes report all-zero flags, including zero.
          zero_d = (bus.op <= OP_SRA) && (result_d == '0);
        end
      end
      SHIFT: begin
        result_d = shifted;
        zero_d   = (shifted == '0);
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_pipe_alu.sv
// tb_pipe_alu -- self-checking bench for pipe_alu at WIDTH=8.
// Directed vectors cover the documented corner cases, followed by random
// requests checked against an arithmetic reference model.
module tb_pipe_alu;
  localparam int W = 8;

  logic clk;
  logic rst;
  int   numChecks;
  int   numFails;

  pipe_alu_if #(.WIDTH(W)) bus ();

  pipe_alu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definitions.
  task automatic refAlu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic z, output logic c,
                        output logic v, output int lat);
    int ia, ib, sa, sb, s, sv, k;
    ia = a; ib = b;
    sa = $signed(a); sb = $signed(b);
    k = ib % 8;
    r = 8'h00; c = 1'b0; v = 1'b0; lat = 1;
    case (op)
      4'd0: begin s = ia + ib; r = 8'(s); c = (s > 255); sv = sa + sb; v = (sv > 127) || (sv < -128); end
      4'd1: begin s = ia - ib; r = 8'(s); c = (ia >= ib); sv = sa - sb; v = (sv > 127) || (sv < -128); end
      4'd2: r = 8'(255 - ia);
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = (sa < sb) ? 8'd1 : 8'd0;
      4'd7: r = (ia == ib) ? 8'd1 : 8'd0;
      4'd8: r = (ia < ib) ? 8'd1 : 8'd0;
      4'd9:  begin r = 8'(ia << k); lat = 1 + k; end
      4'd10: begin r = 8'(ia >> k); lat = 1 + k; end
      4'd11: begin r = 8'(sa >>> k); lat = 1 + k; end
      default: r = 8'h00;
    endcase
    z = (op <= 4'd11) && (r == 8'h00);
  endtask

  // One full request: accept, latency count with junk pulses on in_valid,
  // result/flag checks, optional backpressure hold, then release to IDLE.
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input int holdCycles);
    logic [7:0] er;
    logic ez, ec, ev;
    int   lat, n;
    refAlu(op, a, b, er, ez, ec, ev, lat);

    @(negedge clk);
    checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    @(negedge clk);
    n = 1;
    while (!bus.out_valid && n < 64) begin
      checkOutput("in_ready_busy", 32'(bus.in_ready), 32'd0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    checkOutput("latency", 32'(n), 32'(lat));
    checkOutput("result", 32'(bus.result), 32'(er));
    checkOutput("zero", 32'(bus.zero), 32'(ez));
    checkOutput("carry", 32'(bus.carry), 32'(ec));
    checkOutput("overflow", 32'(bus.overflow), 32'(ev));

    for (int i = 0; i < holdCycles; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op = 4'($urandom); bus.a = 8'($urandom); bus.b = 8'($urandom);
      @(negedge clk);
      checkOutput("hold_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("hold_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("hold_result", 32'(bus.result), 32'(er));
      checkOutput("hold_flags", {29'd0, bus.zero, bus.carry, bus.overflow}, {29'd0, ez, ec, ev});
    end

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("released_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("released_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b0;
  endtask

  logic [3:0] dOp [9] = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd11, 4'd9, 4'd0, 4'd13, 4'd7};
  logic [7:0] dA  [9] = '{8'h7F, 8'h05, 8'hFF, 8'hFF, 8'h90, 8'h5A, 8'hC3, 8'hAA, 8'h33};
  logic [7:0] dB  [9] = '{8'h01, 8'h05, 8'h01, 8'h01, 8'h03, 8'h00, 8'h3C, 8'h55, 8'h33};
  int         dH  [9] = '{0, 0, 0, 0, 0, 0, 5, 0, 2};

  initial begin
    numChecks     = 0;
    numFails      = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'd0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_result", 32'(bus.result), 32'd0);
    checkOutput("reset_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_flags", {29'd0, bus.zero, bus.carry, bus.overflow}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 9; i++) applyStimulus(dOp[i], dA[i], dB[i], dH[i]);

    // Reset in the middle of an SRL by 7: after two shift edges.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.op = 4'd10; bus.a = 8'hFF; bus.b = 8'h07;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("mid_shift_value", 32'(bus.result), 32'h3F);
    rst = 1'b1;
    #1;
    checkOutput("abort_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_result", 32'(bus.result), 32'd0);
    checkOutput("abort_flags", {29'd0, bus.zero, bus.carry, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd0, 8'h01, 8'h02, 0);

    for (int i = 0; i < 150; i++)
      applyStimulus(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, 2)));

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end
endmodule
